pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Program-counter and fetch sequencer sitting directly upstream of the byte-addressed instruction memory. It drives the memory read address and paces fetches with a programmable wait count. It holds the PC under stall and applies jump/branch redirects with fixed priority. It flags each cycle in which the addressed instruction fields are valid for decode.

Parameters:
size_ward, 4, instruction memory depth in 32-bit words; power of two, at least 2
FETCH_LAT, 2, clock cycles the memory needs after an address change before its fields are valid; at least 1
ADDR_W, $clog2(size_ward*4), byte-address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  downstream hold; freezes PC while fetch_valid=1
branch_taken  in  1  branch redirect request
branch_offset  in  16  signed word offset, relative to pc_plus4
jump  in  1  jump redirect request
jump_target  in  26  word-index jump target
read_address  out  ADDR_W  current PC, to instruction memory
pc_plus4  out  ADDR_W  read_address+4 modulo 2^ADDR_W
fetch_valid  out  1  instruction fields for read_address are valid this cycle
instr_count  out  32  number of PC advances since reset

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates occur on the rising edge of clk.
- Reset (rst_n=0 at an edge): pc=0, state=S_WAIT, cnt=0, redir_pending=0, instr_count=0. Outputs: read_address=0, pc_plus4=4, fetch_valid=0. Reset overrides every other input and aborts any state, including a pending redirect.
- States: S_WAIT, S_VALID. fetch_valid is 1 exactly when state==S_VALID; it is decoded from the state register, with no combinational path from the inputs.
- S_WAIT:
  - cnt increments each cycle.
  - When cnt==FETCH_LAT-1: state goes to S_VALID and cnt goes to 0.
- S_VALID:
  - stall=1: stay in S_VALID; pc, instr_count and cnt are held.
  - stall=0: pc<=next_pc, instr_count+=1 (wraps at 2^32), state goes to S_WAIT, redir_pending cleared.
- Fetch cadence: one instruction per FETCH_LAT+1 cycles without stall.
- Redirect capture (any state, rst_n=1):
  - If jump or branch_taken is high, the computed target is written to redir_target and redir_pending is set.
  - jump has priority over branch_taken in the same cycle.
  - A later request overwrites an earlier pending one.
- Target arithmetic (all results truncated to ADDR_W):
  - branch target = pc_plus4 + (sign-extended branch_offset << 2).
  - jump target = jump_target << 2, keeping the low ADDR_W bits.
  - Both targets always have bits [1:0]=00.
- next_pc at the advance edge, in priority order:
  - current-cycle jump target;
  - current-cycle branch target;
  - redir_target if redir_pending;
  - otherwise pc_plus4.
- Redirect at the advance edge: a request in the advancing cycle itself is applied directly. It does not also leave a pending entry.
- Wrap-around: pc_plus4 at the top word (2^ADDR_W-4) is 0, so sequential fetch wraps to address 0. No error is flagged.
- read_address[1:0] is always 00.

Test Plan:
1. Reset: size_ward=4, FETCH_LAT=2; rst_n=0 for 3 edges -> read_address=0, pc_plus4=4, fetch_valid=0, instr_count=0. rst_n=1 -> fetch_valid rises after the 2nd edge and is high for 1 cycle.
2. Sequential wrap: no stall, no redirects -> read_address sequence 0,4,8,12,0, each held 3 cycles. instr_count=4 when read_address returns to 0.
3. Stall: at read_address=8, hold stall=1 during S_VALID for 3 cycles -> fetch_valid stays 1, read_address=8, instr_count unchanged. Release -> next address 12.
4. Branch: at pc=4 in S_VALID, branch_taken=1, branch_offset=-2 -> next read_address=0. At pc=0, offset=+1 -> next address 8.
5. Priority and pending:
   - jump=1 with jump_target=3 and branch_taken=1 (offset=+1) in the same cycle -> next read_address=12.
   - branch_taken at pc=0, offset=+2, asserted only during S_WAIT -> applied at the next advance, giving address 12.
6. Reset mid-operation: redirect pending and cnt=1 in S_WAIT, rst_n=0 for 1 edge -> read_address=0, pending cleared. After release the sequence is 0,4 with no redirect applied.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - fetch-side bus between the PC sequencer, decode and instruction memory
interface pc_fetch_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              stall;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic [ADDR_W-1:0] read_address;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_valid;
  logic [31:0]       instr_count;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target,
    output read_address, pc_plus4, fetch_valid, instr_count
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target,
    input  read_address, pc_plus4, fetch_valid, instr_count
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter with paced fetch, stall hold and jump/branch redirect
module pc_fetch_sequencer #(
  parameter int size_ward = 4,
  parameter int FETCH_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_sequencer_if.master   bus
);
  localparam int ADDR_W = $clog2(size_ward * 4);
  localparam int CNT_W  = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_LAT - 1);

  typedef enum logic {S_WAIT, S_VALID} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [31:0]       ic, ic_d;
  logic              pend, pend_d;
  logic [ADDR_W-1:0] tgt, tgt_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       boff_ext;
  logic [31:0]       jt_ext;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] req_tgt;
  logic              req;

  assign pc_plus4   = pc + ADDR_W'(4);
  // Word offsets become byte offsets; the sum is allowed to wrap within ADDR_W.
  assign boff_ext   = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign jt_ext     = {4'b0000, bus.jump_target, 2'b00};
  assign branch_tgt = pc_plus4 + boff_ext[ADDR_W-1:0];
  assign jump_tgt   = jt_ext[ADDR_W-1:0];
  assign req        = bus.jump | bus.branch_taken;
  assign req_tgt    = bus.jump ? jump_tgt : branch_tgt;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pc_d    = pc;
    ic_d    = ic;
    pend_d  = pend;
    tgt_d   = tgt;
    if (req) begin
      pend_d = 1'b1;
      tgt_d  = req_tgt;
    end
    case (state)
      S_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_d = S_VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_VALID: begin
        // A request in the advancing cycle is consumed here, never left pending.
        if (!bus.stall) begin
          if (req)       pc_d = req_tgt;
          else if (pend) pc_d = tgt;
          else           pc_d = pc_plus4;
          ic_d    = ic + 32'd1;
          state_d = S_WAIT;
          pend_d  = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_WAIT;
      cnt   <= '0;
      pc    <= '0;
      ic    <= '0;
      pend  <= 1'b0;
      tgt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pc    <= pc_d;
      ic    <= ic_d;
      pend  <= pend_d;
      tgt   <= tgt_d;
    end
  end

  assign bus.read_address = pc;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.fetch_valid  = (state == S_VALID);
  assign bus.instr_count  = ic;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  pc_fetch_sequencer_if #(.ADDR_W(4)) bus ();

  pc_fetch_sequencer #(.size_ward(4), .FETCH_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_offset = 16'd0;
    bus.jump = 1'b0;
    bus.jump_target = 26'd0;

    // 1. reset
    step(3);
    chk("rst_ra", bus.read_address, 0);
    chk("rst_pp4", bus.pc_plus4, 4);
    chk("rst_fv", bus.fetch_valid, 0);
    chk("rst_ic", bus.instr_count, 0);
    rst_n = 1'b1;
    step(1);
    chk("lat_fv1", bus.fetch_valid, 0);
    step(1);
    chk("lat_fv2", bus.fetch_valid, 1);
    chk("lat_ra2", bus.read_address, 0);
    step(1);
    chk("lat_fv3", bus.fetch_valid, 0);
    chk("seq_ra4", bus.read_address, 4);

    // 2. sequential wrap
    step(2);
    chk("seq_hold4", bus.read_address, 4);
    step(1);
    chk("seq_ra8", bus.read_address, 8);
    step(3);
    chk("seq_ra12", bus.read_address, 12);
    chk("seq_pp4_wrap", bus.pc_plus4, 0);
    step(3);
    chk("seq_ra0", bus.read_address, 0);
    chk("seq_ic4", bus.instr_count, 4);

    // 3. stall at 8
    step(6);
    chk("stl_ra8", bus.read_address, 8);
    chk("stl_ic6", bus.instr_count, 6);
    step(2);
    chk("stl_fv_pre", bus.fetch_valid, 1);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stl_fv", bus.fetch_valid, 1);
      chk("stl_ra", bus.read_address, 8);
      chk("stl_ic", bus.instr_count, 6);
    end
    bus.stall = 1'b0;
    step(1);
    chk("stl_rel_ra", bus.read_address, 12);
    chk("stl_rel_ic", bus.instr_count, 7);

    // 4. branches: 12 -> 0 -> 4, branch -2 at 4, branch +1 at 0
    step(6);
    chk("br_at4", bus.read_address, 4);
    step(2);
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'hFFFE;
    step(1);
    bus.branch_taken = 1'b0;
    chk("br_neg", bus.read_address, 0);
    step(2);
    chk("br_fv", bus.fetch_valid, 1);
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'd1;
    step(1);
    bus.branch_taken = 1'b0;
    chk("br_pos", bus.read_address, 8);
    chk("br_ic", bus.instr_count, 11);

    // 5a. jump beats branch in the same cycle (branch alone would wrap to 0)
    step(2);
    bus.jump = 1'b1;
    bus.jump_target = 26'd3;
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'd1;
    step(1);
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    chk("prio_jump", bus.read_address, 12);

    // 5b. branch during S_WAIT is held pending and applied at the next advance
    step(3);
    chk("pend_at0", bus.read_address, 0);
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'd2;
    step(1);
    bus.branch_taken = 1'b0;
    chk("pend_wait", bus.fetch_valid, 0);
    step(1);
    chk("pend_fv", bus.fetch_valid, 1);
    chk("pend_hold_ra", bus.read_address, 0);
    step(1);
    chk("pend_apply", bus.read_address, 12);
    step(3);
    chk("pend_cleared", bus.read_address, 0);
    chk("pend_ic", bus.instr_count, 15);

    // 6. reset with a pending redirect and cnt=1
    bus.branch_taken = 1'b1;
    bus.branch_offset = 16'd2;
    step(1);
    bus.branch_taken = 1'b0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mrst_ra", bus.read_address, 0);
    chk("mrst_fv", bus.fetch_valid, 0);
    chk("mrst_ic", bus.instr_count, 0);
    step(2);
    chk("mrst_fv2", bus.fetch_valid, 1);
    step(1);
    chk("mrst_seq4", bus.read_address, 4);
    chk("mrst_ic1", bus.instr_count, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
